// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: the fetch FSM state encoding, the sequential
// PC increment, the default reset PC, and a saturating counter helper.
package cpu_pkg;

    localparam int unsigned PC_INCR      = 4;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        ERR
    } fetch_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc_gen.sv
// Next-PC generator: chooses pc+4 or the branch target pc+imm, and flags a
// target that is not word aligned. Purely combinational, so the pipelined
// fetch variant can reuse it unchanged.
module next_pc_gen
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic                  pc_src,
    input  logic [DATA_WIDTH-1:0] imm_op,
    output logic [ADDR_WIDTH-1:0] next_pc,
    output logic                  misalign
);

    // Select sequential or branch target; both adds wrap modulo 2^ADDR_WIDTH.
    always_comb begin
        // NOTE: every output gets a default before any branch so no path can
        // leave it unassigned and infer a latch.
        next_pc = pc + ADDR_WIDTH'(PC_INCR);
        if (pc_src) begin
            next_pc = pc + imm_op[ADDR_WIDTH-1:0];
        end
        misalign = |next_pc[1:0];
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, issues one outstanding read to
// instruction memory (req/ready, then rvalid), holds the returned word for
// decode under valid/ready, and steps the PC by 4 or to a branch target.
// A misaligned target parks the unit in a sticky error state until reset.
// Optional build macro FETCH_PERF_EN adds retired/stall performance counters.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = 32,
    parameter int unsigned          ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC  = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ready,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [ADDR_WIDTH-1:0] pc_out,
    input  logic                  PCsrc,
    input  logic [DATA_WIDTH-1:0] ImmOp,
    output logic                  fetch_err
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]           retired_cnt,
    output logic [31:0]           stall_cnt
`endif
);

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  imem_req_q, imem_req_d;
    logic                  instr_valid_q, instr_valid_d;
    logic                  fetch_err_q, fetch_err_d;

    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  misalign;
    logic                  decode_hs;

    // The held instruction is consumed only while the FSM is in HOLD.
    assign decode_hs = (state_q == HOLD) && instr_ready;

    next_pc_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_next_pc_gen (
        .pc       (pc_q),
        .pc_src   (PCsrc),
        .imm_op   (ImmOp),
        .next_pc  (next_pc),
        .misalign (misalign)
    );

    // FSM next state plus the registered handshake outputs that follow it.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        imem_req_d    = imem_req_q;
        instr_valid_d = instr_valid_q;
        fetch_err_d   = fetch_err_q;
        unique case (state_q)
            IDLE: begin
                state_d    = REQ;
                imem_req_d = 1'b1;
            end
            REQ: begin
                if (imem_ready) begin
                    state_d    = WAIT;
                    imem_req_d = 1'b0;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    instr_d       = imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (misalign) begin
                        // PC keeps the offending instruction's address for debug.
                        state_d     = ERR;
                        fetch_err_d = 1'b1;
                    end else begin
                        pc_d       = next_pc;
                        state_d    = REQ;
                        imem_req_d = 1'b1;
                    end
                end
            end
            ERR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                fetch_err_d   = 1'b1;
            end
            default: begin
                state_d       = IDLE;
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge
        // values regardless of statement order.
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            fetch_err_q   <= fetch_err_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc_out      = pc_q;
    assign fetch_err   = fetch_err_q;

`ifdef FETCH_PERF_EN
    logic [31:0] retired_cnt_q, retired_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating counters of decode handshakes and memory stall cycles.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        if (state_q != ERR) begin
            if (decode_hs) begin
                retired_cnt_d = sat_inc32(retired_cnt_q);
            end
            if (((state_q == REQ) && !imem_ready) ||
                ((state_q == WAIT) && !imem_rvalid)) begin
                stall_cnt_d = sat_inc32(stall_cnt_q);
            end
        end
    end

    // Counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            retired_cnt_q <= retired_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign retired_cnt = retired_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a small instruction memory responder,
// a table of branch/sequential decode handshakes, and directed sequences for
// memory stalls, decode backpressure, misaligned-target error and reset
// during an outstanding read.
module tb_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc_out;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        fetch_err;
`ifdef FETCH_PERF_EN
    logic [31:0] retired_cnt;
    logic [31:0] stall_cnt;
`endif

    fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc_out      (pc_out),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp),
        .fetch_err   (fetch_err)
`ifdef FETCH_PERF_EN
        ,
        .retired_cnt (retired_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A};
    endfunction

    // Memory responder: accepts when enabled, returns data once rvalid_en allows.
    logic        mem_ready_en = 1'b1;
    logic        rvalid_en    = 1'b1;
    logic        pend         = 1'b0;
    logic [31:0] pend_addr    = 32'h0;

    assign imem_ready  = mem_ready_en;
    assign imem_rvalid = pend && rvalid_en;
    assign imem_rdata  = mem_word(pend_addr);

    always @(posedge clk) begin
        if (imem_req && imem_ready) begin
            pend      <= 1'b1;
            pend_addr <= imem_addr;
        end else if (imem_rvalid) begin
            pend <= 1'b0;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({name, " valid"}, {31'b0, instr_valid}, 32'd1);
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (imem_req !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check({name, " req"}, {31'b0, imem_req}, 32'd1);
    endtask

    // Hold reset two cycles, check reset values, release in IDLE.
    task automatic do_reset(input string name);
        rst         = 1'b1;
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        tick();
        tick();
        check({name, " rst req"},   {31'b0, imem_req},    32'd0);
        check({name, " rst valid"}, {31'b0, instr_valid}, 32'd0);
        check({name, " rst err"},   {31'b0, fetch_err},   32'd0);
        check({name, " rst instr"}, instr,                32'h0);
        check({name, " rst pc"},    pc_out,               32'h0);
        check({name, " rst addr"},  imem_addr,            32'h0);
`ifdef FETCH_PERF_EN
        check({name, " rst retired"}, retired_cnt, 32'd0);
        check({name, " rst stall"},   stall_cnt,   32'd0);
`endif
        rst = 1'b0;
    endtask

    // One decode handshake with the given branch inputs.
    task automatic handshake(input logic src, input logic [31:0] imm);
        PCsrc       = src;
        ImmOp       = imm;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        src;
        logic [31:0] imm;
        logic [31:0] next;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int          n_valid;
        int          n_req;
        int          valid_cyc[3];
        logic [31:0] req_addr[3];

        vecs[0] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004};
        vecs[1] = '{32'h0000_0004, 1'b1, 32'h0000_000C, 32'h0000_0010};
        vecs[2] = '{32'h0000_0010, 1'b1, 32'hFFFF_FFF8, 32'h0000_0008};
        vecs[3] = '{32'h0000_0008, 1'b0, 32'h0000_1234, 32'h0000_000C};
        vecs[4] = '{32'h0000_000C, 1'b0, 32'h0000_0000, 32'h0000_0010};
        vecs[5] = '{32'h0000_0010, 1'b1, 32'h0000_0100, 32'h0000_0110};
        vecs[6] = '{32'h0000_0110, 1'b1, 32'hFFFF_FEEC, 32'hFFFF_FFFC};
        vecs[7] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000};
        vecs[8] = '{32'h0000_0000, 1'b1, 32'h0000_0040, 32'h0000_0040};
        vecs[9] = '{32'h0000_0040, 1'b0, 32'h0000_0002, 32'h0000_0044};

        // Zero-wait memory with decode always ready: 0x0, 0x4, 0x8, 3 cycles each.
        mem_ready_en = 1'b1;
        rvalid_en    = 1'b1;
        do_reset("init");
        instr_ready = 1'b1;
        n_valid = 0;
        n_req   = 0;
        for (int cyc = 0; cyc < 20 && n_valid < 3; cyc++) begin
            tick();
            if (imem_req === 1'b1 && n_req < 3) begin
                req_addr[n_req] = imem_addr;
                n_req++;
            end
            if (instr_valid === 1'b1) begin
                check("stream instr", instr, mem_word(32'(n_valid * 4)));
                check("stream pc", pc_out, 32'(n_valid * 4));
                valid_cyc[n_valid] = cyc;
                n_valid++;
            end
        end
        check("stream valid count", 32'(n_valid), 32'd3);
        check("stream req count", 32'(n_req), 32'd3);
        for (int i = 0; i < n_req; i++) check("stream addr", req_addr[i], 32'(i * 4));
        if (n_valid == 3) begin
            check("stream gap 1", 32'(valid_cyc[1] - valid_cyc[0]), 32'd3);
            check("stream gap 2", 32'(valid_cyc[2] - valid_cyc[1]), 32'd3);
        end
        instr_ready = 1'b0;

        // Table of handshakes chaining the PC through branches and wraparound.
        do_reset("table");
        for (int i = 0; i < 10; i++) begin
            wait_valid("table");
            check("table pc", pc_out, vecs[i].pc);
            check("table instr", instr, mem_word(vecs[i].pc));
            handshake(vecs[i].src, vecs[i].imm);
            check("table next req", {31'b0, imem_req}, 32'd1);
            check("table next addr", imem_addr, vecs[i].next);
            check("table no err", {31'b0, fetch_err}, 32'd0);
        end
`ifdef FETCH_PERF_EN
        check("table retired", retired_cnt, 32'd10);
        check("table stall", stall_cnt, 32'd0);
`endif

        // imem_ready low for 5 cycles in REQ.
        mem_ready_en = 1'b0;
        do_reset("stall");
        tick();
        for (int k = 0; k < 6; k++) begin
            check("stall req", {31'b0, imem_req}, 32'd1);
            check("stall addr", imem_addr, 32'h0);
            check("stall no valid", {31'b0, instr_valid}, 32'd0);
            if (k == 5) mem_ready_en = 1'b1;
            tick();
        end
        wait_valid("stall");
        check("stall instr", instr, mem_word(32'h0));
`ifdef FETCH_PERF_EN
        check("stall cnt", stall_cnt, 32'd5);
        check("stall retired", retired_cnt, 32'd0);
`endif

        // Decode backpressure for 4 cycles in HOLD, then one handshake.
        for (int k = 0; k < 4; k++) begin
            check("bp valid", {31'b0, instr_valid}, 32'd1);
            check("bp instr", instr, mem_word(32'h0));
            check("bp pc", pc_out, 32'h0);
            check("bp no req", {31'b0, imem_req}, 32'd0);
            tick();
        end
        handshake(1'b0, 32'h0);
        check("bp next req", {31'b0, imem_req}, 32'd1);
        check("bp next addr", imem_addr, 32'h4);
        check("bp valid drop", {31'b0, instr_valid}, 32'd0);
`ifdef FETCH_PERF_EN
        check("bp retired", retired_cnt, 32'd1);
        check("bp stall", stall_cnt, 32'd5);
`endif

        // Misaligned branch target at pc 0x20 enters the sticky error state.
        do_reset("err");
        wait_valid("err first");
        handshake(1'b1, 32'h20);
        wait_valid("err second");
        check("err pre pc", pc_out, 32'h20);
        handshake(1'b1, 32'h6);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("err flag", {31'b0, fetch_err}, 32'd1);
            check("err no req", {31'b0, imem_req}, 32'd0);
            check("err no valid", {31'b0, instr_valid}, 32'd0);
            check("err pc", pc_out, 32'h20);
            tick();
        end
`ifdef FETCH_PERF_EN
        check("err retired frozen", retired_cnt, 32'd2);
`endif
        do_reset("err exit");
        wait_req("err restart");
        check("err restart addr", imem_addr, 32'h0);
        check("err cleared", {31'b0, fetch_err}, 32'd0);

        // Reset while WAITing, then a stray rvalid lands in IDLE.
        do_reset("stray");
        wait_valid("stray first");
        handshake(1'b0, 32'h0);
        check("stray req addr", imem_addr, 32'h4);
        rvalid_en = 1'b0;
        tick();
        check("stray in wait", {31'b0, imem_req}, 32'd0);
        do_reset("stray rst");
        rvalid_en = 1'b1;
        tick();
        check("stray ignored", {31'b0, instr_valid}, 32'd0);
        check("stray req", {31'b0, imem_req}, 32'd1);
        check("stray addr", imem_addr, 32'h0);
        wait_valid("stray refetch");
        check("stray instr", instr, mem_word(32'h0));
        check("stray pc", pc_out, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
